// File: rtl/regfile_sb.sv
// RV32I integer register file with 1-cycle registered operand reads and a pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN: same-cycle writeback-to-read bypass (default: read-before-write).
module regfile_sb #(
  parameter int W    = 32,
  parameter int NREG = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         wb_valid_i,
  input  logic [W-1:0] wb_instr_i,
  input  logic [W-1:0] wb_data_i,
  input  logic [W-1:0] id_instr_i,
  input  logic         stall_i,
  input  logic         issue_valid_i,
  input  logic [W-1:0] issue_instr_i,
  input  logic         flush_i,
  output logic [W-1:0] rs1_data_o,
  output logic [W-1:0] rs2_data_o,
  output logic         rs1_busy_o,
  output logic         rs2_busy_o
);

  localparam int AW = $clog2(NREG);

  function automatic logic is_writer(input logic [6:0] op);
    case (op)
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
      7'b0000011, 7'b0010011, 7'b0110011: is_writer = 1'b1;
      default:                            is_writer = 1'b0;
    endcase
  endfunction

  logic [W-1:0]    regs_q [NREG];
  logic [NREG-1:0] sb_q, sb_d;
  logic [W-1:0]    rs1_data_q, rs2_data_q, rs1_data_d, rs2_data_d;
  logic            rs1_busy_q, rs2_busy_q, rs1_busy_d, rs2_busy_d;
  logic [AW-1:0]   wb_rd_s, iss_rd_s, rs1_s, rs2_s;
  logic            wen_s, set_s;
  logic            unused_s;

  assign wb_rd_s  = wb_instr_i[7 +: AW];
  assign iss_rd_s = issue_instr_i[7 +: AW];
  assign rs1_s    = id_instr_i[15 +: AW];
  assign rs2_s    = id_instr_i[20 +: AW];
  assign wen_s    = wb_valid_i & is_writer(wb_instr_i[6:0]) & (wb_rd_s != '0);
  assign set_s    = issue_valid_i & is_writer(issue_instr_i[6:0]) & (iss_rd_s != '0);
  assign unused_s = ^{wb_instr_i[W-1:12], id_instr_i[W-1:25], id_instr_i[14:0],
                      issue_instr_i[W-1:12]};

  // Scoreboard next state: clear on writeback, newer issue wins, flush clears all.
  always_comb begin
    sb_d = sb_q;
    if (wen_s) sb_d[wb_rd_s] = 1'b0;
    if (set_s) sb_d[iss_rd_s] = 1'b1;
    if (flush_i) sb_d = '0;
    sb_d[0] = 1'b0;
  end

  // Operand selection for the registered read ports.
  always_comb begin
    rs1_data_d = (rs1_s == '0) ? '0 : regs_q[rs1_s];
    rs2_data_d = (rs2_s == '0) ? '0 : regs_q[rs2_s];
    rs1_busy_d = sb_q[rs1_s];
    rs2_busy_d = sb_q[rs2_s];
`ifdef REGFILE_BYPASS_EN
    if (wen_s && (wb_rd_s == rs1_s)) begin
      rs1_data_d = wb_data_i;
      rs1_busy_d = sb_d[rs1_s];
    end
    if (wen_s && (wb_rd_s == rs2_s)) begin
      rs2_data_d = wb_data_i;
      rs2_busy_d = sb_d[rs2_s];
    end
`endif
  end

  // Register array; x0 is never written so it stays zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wen_s) begin
      regs_q[wb_rd_s] <= wb_data_i;
    end
  end

  // Scoreboard state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sb_q <= '0;
    else         sb_q <= sb_d;
  end

  // Read output registers, held while stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rs1_busy_q <= 1'b0;
      rs2_busy_q <= 1'b0;
    end else if (!stall_i) begin
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      rs1_busy_q <= rs1_busy_d;
      rs2_busy_q <= rs2_busy_d;
    end
  end

  assign rs1_data_o = rs1_data_q;
  assign rs2_data_o = rs2_data_q;
  assign rs1_busy_o = rs1_busy_q;
  assign rs2_busy_o = rs2_busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic vs. an array-based model.
module tb_regfile_sb;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        wb_valid_i, stall_i, issue_valid_i, flush_i;
  logic [31:0] wb_instr_i, wb_data_i, id_instr_i, issue_instr_i;
  logic [31:0] rs1_data_o, rs2_data_o;
  logic        rs1_busy_o, rs2_busy_o;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [31:0] m_reg [32];
  bit          m_sb  [32];
  logic [31:0] exp_rs1, exp_rs2;
  bit          exp_b1, exp_b2;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  regfile_sb dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .wb_valid_i(wb_valid_i), .wb_instr_i(wb_instr_i),
    .wb_data_i(wb_data_i), .id_instr_i(id_instr_i), .stall_i(stall_i),
    .issue_valid_i(issue_valid_i), .issue_instr_i(issue_instr_i), .flush_i(flush_i),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic bit writes(input logic [6:0] op);
    return op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                      7'b0000011, 7'b0010011, 7'b0110011};
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, op};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [12];
    logic [31:0] v;
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011, 7'b0010011,
            7'b0110011, 7'b0100011, 7'b1100011, 7'b0001111, 7'b1110011, 7'b1111111};
    v = $urandom;
    v[6:0] = ops[$urandom_range(0, 11)];
    return v;
  endfunction

  task automatic set_idle();
    wb_valid_i = 1'b0; wb_instr_i = 32'd0; wb_data_i = 32'd0; id_instr_i = 32'd0;
    stall_i = 1'b0; issue_valid_i = 1'b0; issue_instr_i = 32'd0; flush_i = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin m_reg[i] = 32'd0; m_sb[i] = 1'b0; end
    exp_rs1 = 32'd0; exp_rs2 = 32'd0; exp_b1 = 1'b0; exp_b2 = 1'b0;
  endtask

  // One clock edge: the model applies the architectural rules to the inputs present at the edge.
  task automatic tick();
    logic [4:0] wrd, ird, r1, r2;
    bit wen, setb;
    wrd = wb_instr_i[11:7]; ird = issue_instr_i[11:7];
    r1 = id_instr_i[19:15]; r2 = id_instr_i[24:20];
    wen  = wb_valid_i && writes(wb_instr_i[6:0]) && (wrd != 5'd0);
    setb = issue_valid_i && writes(issue_instr_i[6:0]) && (ird != 5'd0);
    @(posedge clk_i); #1;
    if (!stall_i) begin
      exp_rs1 = (r1 == 5'd0) ? 32'd0 : m_reg[r1]; exp_b1 = m_sb[r1];
      exp_rs2 = (r2 == 5'd0) ? 32'd0 : m_reg[r2]; exp_b2 = m_sb[r2];
    end
    if (wen) begin m_reg[wrd] = wb_data_i; m_sb[wrd] = 1'b0; end
    if (setb) m_sb[ird] = 1'b1;
    if (flush_i) for (int i = 0; i < 32; i++) m_sb[i] = 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (!stall_i && wen && wrd == r1) begin exp_rs1 = wb_data_i; exp_b1 = m_sb[r1]; end
    if (!stall_i && wen && wrd == r2) begin exp_rs2 = wb_data_i; exp_b2 = m_sb[r2]; end
`endif
  endtask

  task automatic wb_write(input logic [4:0] rd, input logic [31:0] d);
    set_idle();
    wb_valid_i = 1'b1; wb_instr_i = mk(OP_ADDI, rd, 5'd0, 5'd0); wb_data_i = d;
    tick();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 4; c++) begin
      wb_valid_i = 1'b1; wb_instr_i = rand_instr(); wb_data_i = $urandom;
      id_instr_i = $urandom; issue_valid_i = 1'b1; issue_instr_i = rand_instr();
      stall_i = 1'b0; flush_i = 1'b0;
      @(posedge clk_i); #1;
      n_tests++;
      if ({rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o} !== 66'd0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %h %h %b %b, want all 0",
                 rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o);
      end
    end
    model_clear();
    set_idle();
    rst_ni = 1'b1;
    id_instr_i = mk(OP_ADDI, 5'd0, 5'd5, 5'd5);
    tick();
    n_tests++;
    if (rs1_data_o !== 32'd0 || exp_rs1 !== 32'd0) begin
      n_fail++; $display("FAIL reset_read_x5: got %h, want 0", rs1_data_o);
    end
  endtask

  task automatic test_write_read();
    wb_write(5'd3, 32'hDEADBEEF);
    set_idle(); id_instr_i = mk(OP_ADDI, 5'd0, 5'd3, 5'd0);
    tick();
    n_tests++;
    if (rs1_data_o !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL write_read_x3: got %h, want deadbeef", rs1_data_o);
    end
  endtask

  task automatic test_x0_nonwriters();
    wb_write(5'd0, 32'h00001234);
    wb_write(5'd7, 32'h77777777);
    set_idle();
    wb_valid_i = 1'b1; wb_instr_i = mk(OP_STORE, 5'd7, 5'd1, 5'd2); wb_data_i = 32'hBAD0BAD0;
    tick();
    set_idle(); id_instr_i = mk(OP_ADDI, 5'd0, 5'd0, 5'd7);
    tick();
    n_tests++;
    if (rs1_data_o !== 32'd0 || rs1_busy_o !== 1'b0) begin
      n_fail++; $display("FAIL x0_read: got %h busy %b, want 0 busy 0", rs1_data_o, rs1_busy_o);
    end
    n_tests++;
    if (rs2_data_o !== 32'h77777777) begin
      n_fail++; $display("FAIL store_no_write_x7: got %h, want 77777777", rs2_data_o);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] want;
    wb_write(5'd9, 32'h0F0F0F0F);
    set_idle();
    wb_valid_i = 1'b1; wb_instr_i = mk(OP_ADDI, 5'd9, 5'd0, 5'd0); wb_data_i = 32'hA5A5A5A5;
    id_instr_i = mk(OP_ADDI, 5'd0, 5'd0, 5'd9);
    tick();
`ifdef REGFILE_BYPASS_EN
    want = 32'hA5A5A5A5;
`else
    want = 32'h0F0F0F0F;
`endif
    n_tests++;
    if (rs2_data_o !== want) begin
      n_fail++; $display("FAIL same_cycle_x9: got %h, want %h", rs2_data_o, want);
    end
    set_idle(); id_instr_i = mk(OP_ADDI, 5'd0, 5'd0, 5'd9);
    tick();
    n_tests++;
    if (rs2_data_o !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL after_write_x9: got %h, want a5a5a5a5", rs2_data_o);
    end
  endtask

  task automatic test_scoreboard();
    set_idle(); flush_i = 1'b1; tick();
    set_idle(); issue_valid_i = 1'b1; issue_instr_i = mk(OP_LW, 5'd4, 5'd1, 5'd0); tick();
    set_idle(); id_instr_i = mk(OP_ADDI, 5'd0, 5'd4, 5'd0); tick();
    n_tests++;
    if (rs1_busy_o !== 1'b1) begin
      n_fail++; $display("FAIL sb_set_x4: got %b, want 1", rs1_busy_o);
    end
    set_idle(); wb_valid_i = 1'b1; wb_instr_i = mk(OP_LW, 5'd4, 5'd0, 5'd0);
    wb_data_i = 32'h44; tick();
    set_idle(); id_instr_i = mk(OP_ADDI, 5'd0, 5'd4, 5'd0); tick();
    n_tests++;
    if (rs1_busy_o !== 1'b0) begin
      n_fail++; $display("FAIL sb_clear_x4: got %b, want 0", rs1_busy_o);
    end
    set_idle(); wb_valid_i = 1'b1; wb_instr_i = mk(OP_LW, 5'd4, 5'd0, 5'd0);
    wb_data_i = 32'h45; issue_valid_i = 1'b1; issue_instr_i = mk(OP_LW, 5'd4, 5'd0, 5'd0);
    tick();
    set_idle(); id_instr_i = mk(OP_ADDI, 5'd0, 5'd4, 5'd0); tick();
    n_tests++;
    if (rs1_busy_o !== 1'b1) begin
      n_fail++; $display("FAIL sb_set_wins_x4: got %b, want 1", rs1_busy_o);
    end
    set_idle(); flush_i = 1'b1; issue_valid_i = 1'b1;
    issue_instr_i = mk(OP_LW, 5'd6, 5'd0, 5'd0); tick();
    set_idle(); id_instr_i = mk(OP_ADDI, 5'd0, 5'd4, 5'd6); tick();
    n_tests++;
    if (rs1_busy_o !== 1'b0 || rs2_busy_o !== 1'b0) begin
      n_fail++; $display("FAIL sb_flush: got %b %b, want 0 0", rs1_busy_o, rs2_busy_o);
    end
  endtask

  task automatic test_stall();
    logic [4:0]  tgt  [3];
    logic [31:0] vals [3];
    tgt = '{5'd10, 5'd11, 5'd10};
    vals = '{32'h333, 32'h444, 32'h555};
    wb_write(5'd10, 32'h111);
    wb_write(5'd11, 32'h222);
    set_idle(); id_instr_i = mk(OP_ADDI, 5'd0, 5'd10, 5'd11); tick();
    for (int c = 0; c < 3; c++) begin
      set_idle(); stall_i = 1'b1;
      id_instr_i = mk(OP_ADDI, 5'd0, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)));
      wb_valid_i = 1'b1; wb_instr_i = mk(OP_ADDI, tgt[c], 5'd0, 5'd0); wb_data_i = vals[c];
      tick();
      n_tests++;
      if (rs1_data_o !== 32'h111 || rs2_data_o !== 32'h222) begin
        n_fail++; $display("FAIL stall_hold_%0d: got %h %h, want 111 222", c, rs1_data_o, rs2_data_o);
      end
    end
    set_idle(); id_instr_i = mk(OP_ADDI, 5'd0, 5'd10, 5'd11); tick();
    n_tests++;
    if (rs1_data_o !== 32'h555 || rs2_data_o !== 32'h444) begin
      n_fail++; $display("FAIL stall_release: got %h %h, want 555 444", rs1_data_o, rs2_data_o);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      wb_valid_i = ($urandom_range(0, 3) != 0); wb_instr_i = rand_instr(); wb_data_i = $urandom;
      id_instr_i = $urandom; stall_i = ($urandom_range(0, 4) == 0);
      issue_valid_i = ($urandom_range(0, 1) == 0); issue_instr_i = rand_instr();
      flush_i = ($urandom_range(0, 19) == 0);
      tick();
      n_tests++;
      if (rs1_data_o !== exp_rs1) begin
        n_fail++; $display("FAIL rand_rs1_data c%0d: got %h, want %h", c, rs1_data_o, exp_rs1);
      end
      n_tests++;
      if (rs2_data_o !== exp_rs2) begin
        n_fail++; $display("FAIL rand_rs2_data c%0d: got %h, want %h", c, rs2_data_o, exp_rs2);
      end
      n_tests++;
      if (rs1_busy_o !== exp_b1) begin
        n_fail++; $display("FAIL rand_rs1_busy c%0d: got %b, want %b", c, rs1_busy_o, exp_b1);
      end
      n_tests++;
      if (rs2_busy_o !== exp_b2) begin
        n_fail++; $display("FAIL rand_rs2_busy c%0d: got %b, want %b", c, rs2_busy_o, exp_b2);
      end
    end
  endtask

  initial begin
    set_idle();
    model_clear();
    test_reset();
    test_write_read();
    test_x0_nonwriters();
    test_bypass();
    test_scoreboard();
    test_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
